elevator_call_scheduler: RTL and testbench
==========================================

// Module: elevator_call_scheduler
// PURPOSE
//  Request-side controller for the car-motion FSM. It latches hall/car button presses into a
//  pending set, chooses the next target floor using a SCAN policy, drives target_floor into the
//  motion FSM's floor input, and reads back the motion FSM's current-floor output (cf).
//  It times the door dwell on arrival and clears the serviced call.
// PARAMETERS
//  NUM_FLOORS   4                   number of floors, >=2
//  FLOOR_W      $clog2(NUM_FLOORS)  floor index width
//  DOOR_CYCLES  4                   clk cycles the door stays open per stop, >=1
// PORTS
//  clk           in   1           rising-edge clock, single domain
//  rst_n         in   1           asynchronous, active-low reset
//  call_req      in   NUM_FLOORS  button pulses, one bit per floor, sampled each clk
//  cf            in   FLOOR_W     current floor reported by the motion FSM
//  target_floor  out  FLOOR_W     floor request to the motion FSM
//  target_valid  out  1           target_floor is a live request
//  door_open     out  1           door open, in DOOR state
//  dir_up        out  1           SCAN direction: 1 = up, 0 = down
//  pending       out  NUM_FLOORS  latched outstanding calls
// BEHAVIOUR
//  Reset values: state=IDLE, pending=0, target_floor=0, target_valid=0, door_open=0,
//    dir_up=1, timer=0.
//  All outputs are registered.
//  States:
//    IDLE
//      - Exit when pending != 0.
//      - Call at cf -> DOOR.
//      - Otherwise pick a target and go to MOVE.
//    MOVE
//      - target_valid=1.
//      - target_floor re-evaluates every cycle to the nearest pending floor strictly ahead of
//        cf in dir_up.
//      - A new call between cf and the current target retargets on the next cycle.
//      - On cf==target_floor -> DOOR.
//    DOOR
//      - door_open=1 and target_valid=0.
//      - Entry clears pending[cf] and loads timer=DOOR_CYCLES-1.
//      - The timer decrements; at 0, go to IDLE if pending==0, otherwise to MOVE.
//  Direction rule:
//    - Keep dir_up while any pending call lies ahead of cf in that direction.
//    - Otherwise flip dir_up.
//    - dir_up is updated only when leaving DOOR or IDLE.
//  Set/clear precedence:
//    - pending |= call_req every cycle.
//    - A press on floor cf during DOOR, including the entry cycle, is not latched. It reloads
//      timer=DOOR_CYCLES-1 instead.
//  Latency:
//    - call_req at cycle N makes pending visible at N+1.
//    - target_valid rises at N+2 from IDLE.
//  Boundaries:
//    - A call at floor 0 or NUM_FLOORS-1 while moving away is kept and serviced after reversal.
//    - Simultaneous multi-bit call_req latches all bits in the same cycle.
//  Asynchronous reset mid-MOVE or mid-DOOR: all state and outputs return to reset values at
//    once, and pending calls are discarded.
//  If cf >= NUM_FLOORS, the block is forced to IDLE with target_valid=0 until cf is legal.
//    This is unreachable when NUM_FLOORS is a power of 2.
// CONFIGURATION
//  SCHED_DOOR_HOLD_EN
//    - Defined: adds input door_hold (1 bit). While door_hold=1 in DOOR, timer is held at
//      DOOR_CYCLES-1. The door-hold behaviour restarts when door_hold falls.
//    - Undefined: no door_hold port, and the door always closes after DOOR_CYCLES cycles
//      (plus reloads).
// STRUCTURE
//  Package elev_pkg:
//    - floor_t typedef (FLOOR_W bits).
//    - sched_state_e enum {IDLE, MOVE, DOOR}.
//    - DOOR_CYCLES default constant.
//  Sub-module elev_call_picker (combinational):
//    - Inputs pending, cf, dir_up.
//    - Outputs: nearest-ahead floor and found flag, nearest-behind floor and found flag.
//  Top level: state register, pending register, door timer, output registers.
// TESTING
//  1. Reset, then call_req=0b1000 with cf=0:
//     - target_floor=3 and target_valid=1 two cycles later.
//     - When cf reaches 3: door_open for 4 cycles, pending=0, back to IDLE.
//  2. While moving up to 3 from cf=0, inject call_req=0b0100 before cf=2:
//     - Retarget to 2, stop with door open, then continue to 3.
//  3. cf=2 with dir_up=1, pending={0,3}:
//     - Service 3 first.
//     - Then dir_up=0 and target=0.
//  4. In DOOR at cf=1, press call_req[1] at timer=1:
//     - Timer reloads to 3 and pending[1] stays 0.
//  5. Assert rst_n=0 asynchronously mid-MOVE with pending=0b1010:
//     - All outputs go to reset values immediately.
//     - pending=0 after release.
//  6. With SCHED_DOOR_HOLD_EN defined, hold door_hold=1 for 10 cycles in DOOR:
//     - door_open stays 1 throughout.
//     - Door closes 4 cycles after release.

Source files
------------

// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared types and defaults for the elevator call scheduler
package elev_pkg;

   localparam int NUM_FLOORS_DEF  = 4;
   localparam int FLOOR_W_DEF     = $clog2(NUM_FLOORS_DEF);
   localparam int DOOR_CYCLES_DEF = 4;

   typedef logic [FLOOR_W_DEF-1:0] floor_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } sched_state_e;

endpackage

// File: rtl/elev_call_picker.sv
// rtl/elev_call_picker.sv - nearest pending floor ahead of and behind cf in the SCAN direction
module elev_call_picker
   import elev_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    cf,
   input  logic                  dir_up,
   output logic [FLOOR_W-1:0]    ahead_floor,
   output logic                  ahead_found,
   output logic [FLOOR_W-1:0]    behind_floor,
   output logic                  behind_found
);

   logic [FLOOR_W-1:0] up_floor;
   logic [FLOOR_W-1:0] dn_floor;
   logic               up_found;
   logic               dn_found;

   // Downward scan for "above" and upward scan for "below" so the last hit is the closest one.
   always_comb begin
      up_floor = '0;
      up_found = 1'b0;
      dn_floor = '0;
      dn_found = 1'b0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (FLOOR_W'(i) > cf)) begin
            up_floor = FLOOR_W'(i);
            up_found = 1'b1;
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) < cf)) begin
            dn_floor = FLOOR_W'(i);
            dn_found = 1'b1;
         end
      end
   end

   assign ahead_floor  = dir_up ? up_floor : dn_floor;
   assign ahead_found  = dir_up ? up_found : dn_found;
   assign behind_floor = dir_up ? dn_floor : up_floor;
   assign behind_found = dir_up ? dn_found : up_found;

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler with door dwell timer
// Optional door_hold input enabled by defining SCHED_DOOR_HOLD_EN.
module elevator_call_scheduler
   import elev_pkg::*;
#(
   parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
   parameter int FLOOR_W     = $clog2(NUM_FLOORS),
   parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef SCHED_DOOR_HOLD_EN
   input  logic                  door_hold,
`endif
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    cf,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_valid,
   output logic                  door_open,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0]      TIMER_LOAD  = TW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W:0]   FLOOR_LIMIT = NUM_FLOORS[FLOOR_W:0];

   sched_state_e           state;
   logic [TW-1:0]          timer;
   logic                   cf_legal;
   logic [NUM_FLOORS-1:0]  cf_mask;
   logic [NUM_FLOORS-1:0]  pend_set;
   logic [NUM_FLOORS-1:0]  pend_door;
   logic                   call_at_cf;
   logic                   pend_at_cf;
   logic                   hold_req;
   logic [FLOOR_W-1:0]     ahead_floor;
   logic [FLOOR_W-1:0]     behind_floor;
   logic                   ahead_found;
   logic                   behind_found;
   logic [FLOOR_W-1:0]     depart_floor;

`ifdef SCHED_DOOR_HOLD_EN
   assign hold_req = door_hold;
`else
   assign hold_req = 1'b0;
`endif

   assign cf_legal   = ({1'b0, cf} < FLOOR_LIMIT);
   assign cf_mask    = cf_legal ? (NUM_FLOORS'(1) << cf) : '0;
   assign pend_set   = pending | call_req;
   assign pend_door  = pend_set & ~cf_mask;
   assign call_at_cf = |(call_req & cf_mask);
   assign pend_at_cf = |(pending & cf_mask);

   // Departure keeps direction while something lies ahead, otherwise heads for the behind side.
   assign depart_floor = ahead_found ? ahead_floor : (behind_found ? behind_floor : target_floor);

   elev_call_picker #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_picker (
      .pending      (pending),
      .cf           (cf),
      .dir_up       (dir_up),
      .ahead_floor  (ahead_floor),
      .ahead_found  (ahead_found),
      .behind_floor (behind_floor),
      .behind_found (behind_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pending      <= '0;
         target_floor <= '0;
         target_valid <= 1'b0;
         door_open    <= 1'b0;
         dir_up       <= 1'b1;
         timer        <= '0;
      end else if (!cf_legal) begin
         pending      <= pend_set;
         state        <= IDLE;
         target_valid <= 1'b0;
         door_open    <= 1'b0;
      end else begin
         pending <= pend_set;
         case (state)
            IDLE: begin
               if (pending != '0) begin
                  if (!ahead_found) dir_up <= ~dir_up;
                  if (pend_at_cf) begin
                     state     <= DOOR;
                     door_open <= 1'b1;
                     timer     <= TIMER_LOAD;
                     pending   <= pend_door;
                  end else begin
                     state        <= MOVE;
                     target_valid <= 1'b1;
                     target_floor <= depart_floor;
                  end
               end
            end
            MOVE: begin
               if (cf == target_floor) begin
                  state        <= DOOR;
                  door_open    <= 1'b1;
                  target_valid <= 1'b0;
                  timer        <= TIMER_LOAD;
                  pending      <= pend_door;
               end else if (ahead_found) begin
                  target_floor <= ahead_floor;
               end
            end
            DOOR: begin
               pending <= pend_door;
               if (call_at_cf || hold_req) begin
                  timer <= TIMER_LOAD;
               end else if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else begin
                  door_open <= 1'b0;
                  if (!ahead_found) dir_up <= ~dir_up;
                  if (pending == '0) begin
                     state <= IDLE;
                  end else begin
                     state        <= MOVE;
                     target_valid <= 1'b1;
                     target_floor <= depart_floor;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - vector table, directed corner sequences and random run vs a SCAN reference model
module tb_elevator_call_scheduler;

   localparam int NF = 4;
   localparam int DC = 4;
   localparam int S_IDLE = 0;
   localparam int S_MOVE = 1;
   localparam int S_DOOR = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          door_hold = 1'b0;
   logic [NF-1:0] call_req = '0;
   logic [1:0]    cf = '0;
   logic [1:0]    target_floor;
   logic          target_valid;
   logic          door_open;
   logic          dir_up;
   logic [NF-1:0] pending;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int            m_st, m_tf, m_timer;
   logic          m_tv, m_door, m_dir;
   logic [NF-1:0] m_pend;

   wire [8:0] dut_o = {target_floor, target_valid, door_open, dir_up, pending};

   typedef struct {
      logic [NF-1:0] cr;
      logic [1:0]    cfv;
      logic [8:0]    exp;
   } vec_t;
   vec_t vec[12];

   elevator_call_scheduler #(
      .NUM_FLOORS  (NF),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef SCHED_DOOR_HOLD_EN
      .door_hold    (door_hold),
`endif
      .call_req     (call_req),
      .cf           (cf),
      .target_floor (target_floor),
      .target_valid (target_valid),
      .door_open    (door_open),
      .dir_up       (dir_up),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] pk(input int tf, input logic tv, input logic d, input logic dir,
                                     input logic [NF-1:0] p);
      return {2'(tf), tv, d, dir, p};
   endfunction

   // Closest pending floor by distance in the given direction, -1 if none.
   function automatic int nearest(input logic [NF-1:0] p, input int c, input logic up);
      for (int d = 1; d < NF; d++) begin
         int f;
         f = up ? c + d : c - d;
         if (f >= 0 && f < NF && p[f]) return f;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_pend = '0; m_tf = 0; m_tv = 1'b0;
      m_door = 1'b0; m_dir = 1'b1; m_timer = 0;
   endtask

   task automatic model_step(input logic [NF-1:0] cr, input int c, input logic hold);
      logic [NF-1:0] nxt;
      int a, b;
      nxt = m_pend | cr;
      a = nearest(m_pend, c, m_dir);
      b = nearest(m_pend, c, !m_dir);
      if (m_st == S_IDLE) begin
         if (m_pend != 0) begin
            if (a < 0) m_dir = !m_dir;
            if (m_pend[c]) begin
               m_st = S_DOOR; m_door = 1'b1; m_timer = DC - 1; nxt[c] = 1'b0;
            end else begin
               m_st = S_MOVE; m_tv = 1'b1; m_tf = (a >= 0) ? a : b;
            end
         end
      end else if (m_st == S_MOVE) begin
         if (c == m_tf) begin
            m_st = S_DOOR; m_door = 1'b1; m_tv = 1'b0; m_timer = DC - 1; nxt[c] = 1'b0;
         end else if (a >= 0) begin
            m_tf = a;
         end
      end else begin
         nxt[c] = 1'b0;
         if (cr[c] || hold) m_timer = DC - 1;
         else if (m_timer > 0) m_timer--;
         else begin
            m_door = 1'b0;
            if (a < 0) m_dir = !m_dir;
            if (m_pend == 0) m_st = S_IDLE;
            else begin
               m_st = S_MOVE; m_tv = 1'b1; m_tf = (a >= 0) ? a : b;
            end
         end
      end
      m_pend = nxt;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: dut=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic [NF-1:0] cr, input int cv);
      call_req = cr;
      cf = 2'(cv);
      @(posedge clk);
      model_step(cr, cv, door_hold);
      #1;
      check($sformatf("model cyc%0d", cyc), 32'(dut_o),
            32'(pk(m_tf, m_tv, m_door, m_dir, m_pend)));
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; call_req = '0; cf = '0; door_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      check("reset", 32'(dut_o), 32'(pk(0, 0, 0, 1, 4'b0000)));
   endtask

   initial begin
      int n;
      int cfv;
      logic [NF-1:0] cr;

      vec[0]  = '{4'b1000, 2'd0, pk(0, 0, 0, 1, 4'b1000)};
      vec[1]  = '{4'b0000, 2'd0, pk(3, 1, 0, 1, 4'b1000)};
      vec[2]  = '{4'b0000, 2'd1, pk(3, 1, 0, 1, 4'b1000)};
      vec[3]  = '{4'b0000, 2'd2, pk(3, 1, 0, 1, 4'b1000)};
      vec[4]  = '{4'b0000, 2'd3, pk(3, 0, 1, 1, 4'b0000)};
      vec[5]  = '{4'b0000, 2'd3, pk(3, 0, 1, 1, 4'b0000)};
      vec[6]  = '{4'b0000, 2'd3, pk(3, 0, 1, 1, 4'b0000)};
      vec[7]  = '{4'b0000, 2'd3, pk(3, 0, 1, 1, 4'b0000)};
      vec[8]  = '{4'b0000, 2'd3, pk(3, 0, 0, 0, 4'b0000)};
      vec[9]  = '{4'b0000, 2'd3, pk(3, 0, 0, 0, 4'b0000)};
      vec[10] = '{4'b0001, 2'd3, pk(3, 0, 0, 0, 4'b0001)};
      vec[11] = '{4'b0000, 2'd3, pk(0, 1, 0, 0, 4'b0001)};

      apply_reset();
      for (int i = 0; i < 12; i++) begin
         step(vec[i].cr, int'(vec[i].cfv));
         check($sformatf("vec%0d", i), 32'(dut_o), 32'(vec[i].exp));
      end

      // Retarget to a nearer call picked up on the way, then resume.
      apply_reset();
      step(4'b1000, 0); step(0, 0); step(0, 1); step(4'b0100, 1); step(0, 1);
      check("retarget_tf", 32'(target_floor), 32'd2);
      step(0, 2);
      check("retarget_door", 32'({door_open, pending}), 32'({1'b1, 4'b1000}));
      repeat (4) step(0, 2);
      check("resume_tf", 32'({target_valid, target_floor}), 32'({1'b1, 2'd3}));

      // SCAN ordering with calls at both ends.
      apply_reset();
      step(4'b0100, 0); step(0, 0); step(0, 1); step(0, 2);
      step(4'b1001, 2);
      check("multi_latch", 32'(pending), 32'(4'b1001));
      repeat (3) step(0, 2);
      check("scan_up", 32'({dir_up, target_valid, target_floor}), 32'({1'b1, 1'b1, 2'd3}));
      step(0, 3);
      repeat (4) step(0, 3);
      check("scan_down", 32'({dir_up, target_valid, target_floor}), 32'({1'b0, 1'b1, 2'd0}));

      // Press at the open floor reloads the dwell instead of latching.
      apply_reset();
      step(4'b0010, 0); step(0, 0); step(0, 1); step(0, 1); step(0, 1);
      step(4'b0010, 1);
      check("no_latch", 32'({door_open, pending[1]}), 32'({1'b1, 1'b0}));
      n = 0;
      for (int i = 0; i < 20 && door_open; i++) begin
         step(0, 1);
         if (door_open) n++;
      end
      check("reload_tail", 32'(n), 32'd3);
      check("reload_closed", 32'(door_open), 32'd0);

      // Asynchronous reset in the middle of a move.
      apply_reset();
      step(4'b1010, 0); step(0, 0); step(0, 0);
      check("pre_rst", 32'({target_valid, pending}), 32'({1'b1, 4'b1010}));
      #3 rst_n = 1'b0;
      #1 check("async_rst", 32'(dut_o), 32'(pk(0, 0, 0, 1, 4'b0000)));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 0);
      check("rst_pend", 32'(pending), 32'd0);

`ifdef SCHED_DOOR_HOLD_EN
      apply_reset();
      step(4'b0010, 0); step(0, 0); step(0, 1);
      door_hold = 1'b1;
      n = 0;
      repeat (10) begin
         step(0, 1);
         if (door_open) n++;
      end
      check("hold_open", 32'(n), 32'd10);
      door_hold = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && door_open; i++) begin
         step(0, 1);
         if (door_open) n++;
      end
      check("hold_tail", 32'(n), 32'd3);
`endif

      // Random calls against the reference model with a simple car plant.
      apply_reset();
      cfv = 0;
      for (int i = 0; i < 800; i++) begin
         cr = ($urandom_range(0, 4) == 0) ? NF'($urandom) : '0;
`ifdef SCHED_DOOR_HOLD_EN
         door_hold = ($urandom_range(0, 7) == 0);
`endif
         step(cr, cfv);
         if (m_tv && cfv != m_tf && $urandom_range(0, 3) != 0)
            cfv = (m_tf > cfv) ? cfv + 1 : cfv - 1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
